vcnpu_wb_packer: RTL and testbench
==================================

// Module: vcnpu_wb_packer
// PURPOSE
//  Downstream stage of the VCNPU top: packs the un-throttled output_data/output_valid stream into
//  fixed-size bursts and writes them to external DRAM via a req/ack + valid/ready write port.
//  A ping-pong pair of burst banks absorbs DRAM latency. Source has no backpressure, so words
//  arriving with both banks full are dropped and flagged.
// PARAMETERS
//  DATA_W       16   output word width (multiple of 8)
//  ADDR_W       32   DRAM byte-address width
//  BURST_WORDS  32   words per bank / max burst length (power of 2, >=2)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        reset, asynchronous, active-low
//  start          in   1        launch frame writeback (ignored while busy)
//  out_base_addr  in   ADDR_W   frame byte base address, sampled on accepted start
//  frame_words    in   32       words in frame, sampled on accepted start
//  in_data        in   DATA_W   output word from VCNPU top
//  in_valid       in   1        in_data qualifier, no ready
//  wr_req         out  1        burst request, held until wr_ack
//  wr_addr        out  ADDR_W   burst byte address, stable while wr_req
//  wr_len         out  16       burst length in words, stable while wr_req
//  wr_ack         in   1        DRAM accepts request
//  wr_data        out  DATA_W   burst data beat
//  wr_data_valid  out  1        beat valid
//  wr_data_ready  in   1        DRAM accepts beat
//  busy           out  1        frame in progress
//  done           out  1        1-cycle pulse: last beat of frame accepted
//  overflow       out  1        sticky: word dropped (both banks full); cleared on accepted start
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; both banks empty; counters 0; wr_addr/wr_len/wr_data 0.
//  Accepted start = start && !busy: latch base/frame_words; clear overflow, word counters, bank flags;
//   busy=1 next cycle. If frame_words==0: no request, done pulses the cycle after start, busy stays 0.
//  Fill side (only while busy): each in_valid writes in_data to fill bank at fill_ptr, fill_ptr++.
//   Bank sealed when fill_ptr==BURST_WORDS-1 written OR the frame's final word written (partial);
//   sealed bank length recorded; fill switches to other bank, fill_ptr=0.
//   in_valid when the target bank is sealed/draining: word dropped, overflow<=1, not counted.
//   in_valid beyond frame_words accepted words or while !busy: ignored, no flag.
//  Drain FSM: IDLE -> REQ when oldest sealed bank exists (banks drained in seal order).
//   REQ: wr_req=1, wr_addr=cur_addr, wr_len=bank length; on wr_ack -> DATA (wr_req low next cycle).
//   DATA: wr_data=bank[rd_ptr], wr_data_valid=1; beat on valid&&ready, rd_ptr++. Last beat:
//   bank released (empty), cur_addr += len*(DATA_W/8) (wraps mod 2^ADDR_W); if frame complete ->
//   done pulse that cycle edge, busy=0, IDLE; else another sealed bank -> REQ directly; else IDLE.
//  Frame complete = words drained == frame_words minus dropped words (drops shorten the frame).
//  Simultaneous seal of one bank and release of other in same cycle: both take effect.
//  Min latency: seal -> wr_req asserted next cycle. wr_ack in same cycle as wr_req assertion legal.
//  start while busy: ignored, no effect on overflow. Async reset mid-burst: abandon all; outputs to reset.
// TESTING
//  1 frame_words=64, base=0x1000, continuous in_valid, ack/ready always 1 -> 2 reqs addr 0x1000,0x1040
//    len 32; 64 beats in order; done once; overflow=0.
//  2 frame_words=40 -> 2nd burst len=8 at 0x1040; done after 8th beat of it.
//  3 frame_words=128, ready held 0 for 200 cycles -> words 65+ dropped, overflow=1; done after 64
//    beats; next start clears overflow.
//  4 frame_words=0 start -> done pulse 1 cycle later, wr_req never asserted, busy stays 0.
//  5 wr_ack delayed 10 cycles, ready toggling 1/0 -> wr_addr/wr_len stable during req; data order intact.
//  6 rst_n low mid-DATA beat 5 -> all outputs 0 immediately; new start runs a clean frame.

Source files
------------

// File: rtl/vcnpu_wb_packer.sv
// VCNPU writeback packer: ping-pong burst banks feeding a DRAM write port.
// Words are grouped into bursts; words arriving with both banks full are dropped.
module vcnpu_wb_packer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int BURST_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] out_base_addr,
  input  logic [31:0]       frame_words,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_len,
  input  logic              wr_ack,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int PW    = $clog2(BURST_WORDS);
  localparam int LW    = PW + 1;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, DATA} st_e;
  st_e st_q;

  logic [DATA_W-1:0] mem_q [2][BURST_WORDS];
  logic [1:0]          sealed_q;
  logic [1:0][LW-1:0]  len_q;
  logic                fill_bank_q;
  logic [PW-1:0]       fill_ptr_q;
  logic                rd_bank_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [31:0]         fw_q, seen_q;
  logic [31:0]         drop_q, drn_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic                busy_q, done_q, ovf_q;
  logic                req_q, dv_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wlen_q;
  logic [DATA_W-1:0]   data_q;

  logic go, take, wr_en, drop, seal;
  logic beat, last, nb, complete;
  logic [1:0]        avail;
  logic [LW-1:0]     new_len, rd_len, nb_len, cur_len;
  logic [31:0]       drop_d, drn_d;
  logic [ADDR_W-1:0] addr_d;

  assign go    = start && !busy_q;
  assign take  = busy_q && in_valid && (seen_q != fw_q);
  assign wr_en = take && !sealed_q[fill_bank_q];
  assign drop  = take && sealed_q[fill_bank_q];
  assign seal  = wr_en && ((fill_ptr_q == PW'(BURST_WORDS - 1))
                        || (seen_q + 32'd1 == fw_q));

  // A bank sealing this cycle is already eligible for a request.
  assign avail[0] = sealed_q[0] || (seal && !fill_bank_q);
  assign avail[1] = sealed_q[1] || (seal && fill_bank_q);
  assign new_len  = LW'(fill_ptr_q) + LW'(1);
  assign nb       = ~rd_bank_q;
  assign rd_len   = sealed_q[rd_bank_q] ? len_q[rd_bank_q] : new_len;
  assign nb_len   = sealed_q[nb] ? len_q[nb] : new_len;
  assign cur_len  = len_q[rd_bank_q];

  assign beat = (st_q == DATA) && dv_q && wr_data_ready;
  assign last = beat && (LW'(rd_ptr_q) + LW'(1) == cur_len);

  assign drop_d   = drop_q + 32'(drop);
  assign drn_d    = drn_q + 32'(cur_len);
  assign complete = (drn_d == fw_q - drop_d);
  assign addr_d   = cur_addr_q
                  + ADDR_W'(cur_len) * ADDR_W'(BYTES);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[fill_bank_q][fill_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      sealed_q    <= '0;
      len_q       <= '0;
      fill_bank_q <= 1'b0;
      fill_ptr_q  <= '0;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      fw_q        <= '0;
      seen_q      <= '0;
      drop_q      <= '0;
      drn_q       <= '0;
      cur_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      req_q       <= 1'b0;
      dv_q        <= 1'b0;
      addr_q      <= '0;
      wlen_q      <= '0;
      data_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        fw_q        <= frame_words;
        cur_addr_q  <= out_base_addr;
        seen_q      <= '0;
        drop_q      <= '0;
        drn_q       <= '0;
        ovf_q       <= 1'b0;
        sealed_q    <= '0;
        fill_bank_q <= 1'b0;
        fill_ptr_q  <= '0;
        rd_bank_q   <= 1'b0;
        rd_ptr_q    <= '0;
        busy_q      <= (frame_words != 32'd0);
        done_q      <= (frame_words == 32'd0);
      end else begin
        if (take) seen_q <= seen_q + 32'd1;
        if (drop) begin
          drop_q <= drop_d;
          ovf_q  <= 1'b1;
        end
        if (wr_en) fill_ptr_q <= seal ? '0 : fill_ptr_q + PW'(1);
        if (seal) begin
          sealed_q[fill_bank_q] <= 1'b1;
          len_q[fill_bank_q]    <= new_len;
          fill_bank_q           <= ~fill_bank_q;
        end
        if (last) sealed_q[rd_bank_q] <= 1'b0;
        unique case (st_q)
          IDLE: begin
            if (avail[rd_bank_q]) begin
              st_q   <= REQ;
              req_q  <= 1'b1;
              addr_q <= cur_addr_q;
              wlen_q <= 16'(rd_len);
            end
          end
          REQ: begin
            if (wr_ack) begin
              st_q     <= DATA;
              req_q    <= 1'b0;
              dv_q     <= 1'b1;
              rd_ptr_q <= '0;
              data_q   <= mem_q[rd_bank_q][0];
            end
          end
          DATA: begin
            if (last) begin
              rd_bank_q  <= nb;
              rd_ptr_q   <= '0;
              cur_addr_q <= addr_d;
              drn_q      <= drn_d;
              dv_q       <= 1'b0;
              data_q     <= '0;
              if (complete) begin
                st_q   <= IDLE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else if (avail[nb]) begin
                st_q   <= REQ;
                req_q  <= 1'b1;
                addr_q <= addr_d;
                wlen_q <= 16'(nb_len);
              end else begin
                st_q <= IDLE;
              end
            end else if (beat) begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
              data_q   <= mem_q[rd_bank_q][rd_ptr_q + PW'(1)];
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_req        = req_q;
  assign wr_addr       = addr_q;
  assign wr_len        = wlen_q;
  assign wr_data       = data_q;
  assign wr_data_valid = dv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_vcnpu_wb_packer.sv
// Bench for vcnpu_wb_packer: table of frame scenarios plus
// hand-written zero-length frame and mid-burst reset sequences.
module tb_vcnpu_wb_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] out_base_addr = '0;
  logic [31:0] frame_words = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [15:0] wr_len;
  logic        wr_ack = 1'b0;
  logic [15:0] wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready = 1'b0;
  logic        busy, done, overflow;

  int total = 0;
  int bad   = 0;

  vcnpu_wb_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .out_base_addr(out_base_addr), .frame_words(frame_words),
    .in_data(in_data), .in_valid(in_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_ack(wr_ack), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] fw;
    int          hold;
    int          ackd;
    bit          tog;
    int          nreq;
    logic [31:0] a0, a1;
    logic [15:0] l0, l1;
    int          beats;
    bit          ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int id, input int i);
    return 16'((id << 12) ^ (i * 37 + 5));
  endfunction

  task automatic run(input vec_t v, input int id);
    int sent = 0, nreq = 0, beats = 0, dn = 0, bdone = -1;
    int unst = 0, derr = 0, ackc = 0, post = 0, cyc = 0;
    bit prq = 0;
    logic [31:0] pa = '0;
    logic [15:0] pl = '0;
    logic [31:0] ra[4];
    logic [15:0] rl[4];
    @(posedge clk); #1;
    start = 1'b1;
    out_base_addr = v.base;
    frame_words = v.fw;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("r%0d_ovf_clr", id), 64'(overflow), 64'd0);
    chk($sformatf("r%0d_busy", id), 64'(busy), 64'd1);
    while (post < 6 && cyc < 3000) begin
      in_valid = (sent < int'(v.fw));
      in_data  = in_valid ? word(id, sent) : 16'h0;
      if (in_valid) sent++;
      wr_data_ready = (cyc >= v.hold) && (!v.tog || cyc[0]);
      wr_ack = wr_req && (ackc >= v.ackd);
      @(negedge clk);
      if (wr_req) begin
        if (prq && (wr_addr !== pa || wr_len !== pl)) unst++;
        pa = wr_addr;
        pl = wr_len;
        if (wr_ack) begin
          if (nreq < 4) begin
            ra[nreq] = wr_addr;
            rl[nreq] = wr_len;
          end
          nreq++;
          ackc = 0;
        end else ackc++;
      end
      prq = wr_req && !wr_ack;
      if (wr_data_valid && wr_data_ready) begin
        if (wr_data !== word(id, beats)) derr++;
        beats++;
      end
      if (done) begin
        dn++;
        bdone = beats;
      end
      if (dn > 0) post++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wr_ack = 1'b0;
    if (dn == 0) chk($sformatf("r%0d_timeout", id), 64'd1, 64'd0);
    chk($sformatf("r%0d_nreq", id), 64'(nreq), 64'(v.nreq));
    chk($sformatf("r%0d_addr0", id), 64'(ra[0]), 64'(v.a0));
    chk($sformatf("r%0d_len0", id), 64'(rl[0]), 64'(v.l0));
    if (v.nreq > 1) begin
      chk($sformatf("r%0d_addr1", id), 64'(ra[1]), 64'(v.a1));
      chk($sformatf("r%0d_len1", id), 64'(rl[1]), 64'(v.l1));
    end
    chk($sformatf("r%0d_beats", id), 64'(beats), 64'(v.beats));
    chk($sformatf("r%0d_done_cnt", id), 64'(dn), 64'd1);
    chk($sformatf("r%0d_done_at", id), 64'(bdone), 64'(v.beats));
    chk($sformatf("r%0d_data_err", id), 64'(derr), 64'd0);
    chk($sformatf("r%0d_req_unstable", id), 64'(unst), 64'd0);
    chk($sformatf("r%0d_ovf", id), 64'(overflow), 64'(v.ovf));
    chk($sformatf("r%0d_idle", id), 64'(busy), 64'd0);
  endtask

  initial begin
    int beats, cyc, nreq, nbusy;
    tbl[0] = '{32'h1000, 64, 0, 0, 0, 2, 32'h1000, 32'h1040,
               16'd32, 16'd32, 64, 0};
    tbl[1] = '{32'h1000, 40, 0, 0, 0, 2, 32'h1000, 32'h1040,
               16'd32, 16'd8, 40, 0};
    tbl[2] = '{32'h2000, 128, 200, 0, 0, 2, 32'h2000, 32'h2040,
               16'd32, 16'd32, 64, 1};
    tbl[3] = '{32'h3000, 64, 0, 10, 1, 2, 32'h3000, 32'h3040,
               16'd32, 16'd32, 64, 0};
    tbl[4] = '{32'hFFFF_FFE0, 48, 0, 0, 0, 2, 32'hFFFF_FFE0,
               32'h0000_0020, 16'd32, 16'd16, 48, 0};
    tbl[5] = '{32'h0500, 1, 0, 0, 0, 1, 32'h0500, 32'h0,
               16'd1, 16'd0, 1, 0};
    tbl[6] = '{32'h0600, 33, 0, 0, 0, 2, 32'h0600, 32'h0640,
               16'd32, 16'd1, 33, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(wr_req), 64'd0);
    chk("rst_dv", 64'(wr_data_valid), 64'd0);
    chk("rst_busy_done_ovf", 64'({busy, done, overflow}), 64'd0);
    chk("rst_addr_len_data", 64'({wr_addr, wr_len, wr_data}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i], i);

    // zero-length frame
    @(posedge clk); #1;
    start = 1'b1;
    frame_words = 32'd0;
    out_base_addr = 32'h9000;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("z_done", 64'(done), 64'd1);
    chk("z_busy", 64'(busy), 64'd0);
    nreq = 0;
    nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_req) nreq++;
      if (busy || done) nbusy++;
    end
    chk("z_noreq", 64'(nreq), 64'd0);
    chk("z_nobusy", 64'(nbusy), 64'd0);

    // reset in the middle of a burst
    @(posedge clk); #1;
    start = 1'b1;
    frame_words = 32'd64;
    out_base_addr = 32'h7000;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    cyc = 0;
    wr_data_ready = 1'b1;
    while (beats < 5 && cyc < 200) begin
      in_valid = 1'b1;
      in_data = word(8, cyc);
      wr_ack = wr_req;
      @(negedge clk);
      if (wr_data_valid && wr_data_ready) beats++;
      cyc++;
      if (beats < 5) begin
        @(posedge clk); #1;
      end
    end
    if (beats < 5) chk("rs_timeout", 64'd1, 64'd0);
    chk("rs_in_data", 64'(wr_data_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_req", 64'(wr_req), 64'd0);
    chk("rs_dv", 64'(wr_data_valid), 64'd0);
    chk("rs_flags", 64'({busy, done, overflow}), 64'd0);
    chk("rs_addr_len_data", 64'({wr_addr, wr_len, wr_data}), 64'd0);
    in_valid = 1'b0;
    wr_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(tbl[0], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
